// File: rtl/led_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_ctrl_if
// Description : CPU register bus and LED peripheral write port bundled for
//               the LED sequencer. master = CPU/bus side, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_seq_ctrl_if;
    logic        cpu_cs;
    logic        cpu_write;
    logic [2:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        led_cs;
    logic        led_write;
    logic [1:0]  led_addr;
    logic [15:0] led_wdata;
    logic        busy;

    modport master (
        output cpu_cs, cpu_write, cpu_addr, cpu_wdata,
        input  cpu_rdata, led_cs, led_write, led_addr, led_wdata, busy
    );

    modport slave (
        input  cpu_cs, cpu_write, cpu_addr, cpu_wdata,
        output cpu_rdata, led_cs, led_write, led_addr, led_wdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_ctrl
// Description : Memory-mapped LED sequencer. Forwards CPU pattern writes in
//               DIRECT mode; in BLINK/SHIFT/COUNT it pushes a 24-bit frame
//               to the LED peripheral as a two-beat write on every tick.
// Revision    : 1.0 - initial release
// ============================================================================
module led_seq_ctrl #(
    parameter logic [15:0] DEFAULT_PERIOD = 16'd1000
) (
    input  wire logic     ledctl_clk,
    input  wire logic     ledctl_rst,
    led_seq_ctrl_if.slave bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WR_LO  = 2'd1;
    localparam logic [1:0] c_WR_HI  = 2'd2;

    localparam logic [1:0] c_MODE_DIRECT = 2'd0;
    localparam logic [1:0] c_MODE_BLINK  = 2'd1;
    localparam logic [1:0] c_MODE_SHIFT  = 2'd2;
    localparam logic [1:0] c_MODE_COUNT  = 2'd3;

    localparam logic [2:0] c_ADDR_PATLO  = 3'd0;
    localparam logic [2:0] c_ADDR_PATHI  = 3'd2;
    localparam logic [2:0] c_ADDR_CTRL   = 3'd4;
    localparam logic [2:0] c_ADDR_PERIOD = 3'd6;

    logic [15:0] patlo_q, patlo_d;
    logic [7:0]  pathi_q, pathi_d;
    logic [1:0]  mode_q, mode_d;
    logic        en_q, en_d;
    logic        ovf_q, ovf_d;
    logic [15:0] period_q, period_d;
    logic [23:0] frame_q, frame_d;
    logic [15:0] presc_q, presc_d;
    logic        phase_q, phase_d;
    logic        pending_q, pending_d;
    logic        abort_q, abort_d;
    logic [1:0]  state_q, state_d;
    logic [23:0] burst_q, burst_d;
    logic        fwd_q, fwd_d;
    logic [1:0]  fwd_addr_q, fwd_addr_d;
    logic [15:0] fwd_data_q, fwd_data_d;

    logic        w_wr, w_wr_patlo, w_wr_pathi, w_wr_ctrl, w_wr_period;
    logic        w_engine, w_tick, w_tick_ok, w_tick_drop;
    logic        w_ctrl_change, w_en_rise, w_pat_load, w_fwd_wr;
    logic [15:0] w_eff_period;
    logic [23:0] w_burst_src;

    // Bus decode, prescaler tick and tick-acceptance qualifiers
    always_comb begin
        w_wr          = bus.cpu_cs && bus.cpu_write;
        w_wr_patlo    = w_wr && (bus.cpu_addr == c_ADDR_PATLO);
        w_wr_pathi    = w_wr && (bus.cpu_addr == c_ADDR_PATHI);
        w_wr_ctrl     = w_wr && (bus.cpu_addr == c_ADDR_CTRL);
        w_wr_period   = w_wr && (bus.cpu_addr == c_ADDR_PERIOD);
        w_engine      = en_q && (mode_q != c_MODE_DIRECT);
        // A zero period behaves as a tick every cycle
        w_eff_period  = (period_q == 16'd0) ? 16'd1 : period_q;
        w_tick        = w_engine && (presc_q == (w_eff_period - 16'd1));
        // Only one tick may wait behind a running burst; further ones are lost
        w_tick_drop   = w_tick && pending_q;
        w_tick_ok     = w_tick && !pending_q;
        w_ctrl_change = w_wr_ctrl && ((bus.cpu_wdata[1:0] != mode_q) || !bus.cpu_wdata[2]);
        w_en_rise     = w_wr_ctrl && bus.cpu_wdata[2] && !en_q;
        w_pat_load    = (w_wr_patlo || w_wr_pathi) && w_engine;
        w_fwd_wr      = (w_wr_patlo || w_wr_pathi) && !w_engine;
    end

    // Register file, prescaler, blink phase and frame next-state
    always_comb begin
        patlo_d  = w_wr_patlo ? bus.cpu_wdata : patlo_q;
        pathi_d  = w_wr_pathi ? bus.cpu_wdata[7:0] : pathi_q;
        mode_d   = w_wr_ctrl ? bus.cpu_wdata[1:0] : mode_q;
        en_d     = w_wr_ctrl ? bus.cpu_wdata[2] : en_q;
        period_d = w_wr_period ? bus.cpu_wdata : period_q;

        ovf_d = ovf_q;
        if (w_wr_ctrl && bus.cpu_wdata[3]) ovf_d = 1'b0;
        if (w_tick_drop)                   ovf_d = 1'b1;

        presc_d = presc_q + 16'd1;
        if (!w_engine || w_wr_period || w_tick) presc_d = 16'd0;

        phase_d = phase_q;
        if (!en_q)                                      phase_d = 1'b0;
        else if (w_tick_ok && mode_q == c_MODE_BLINK)   phase_d = ~phase_q;

        frame_d = frame_q;
        if (w_tick_ok) begin
            case (mode_q)
                c_MODE_SHIFT: frame_d = {frame_q[22:0], frame_q[23]};
                c_MODE_COUNT: frame_d = frame_q + 24'd1;
                default:      frame_d = frame_q;
            endcase
        end
        // A fresh pattern overrides any same-cycle frame update
        if (w_en_rise || w_pat_load) frame_d = {pathi_d, patlo_d};

        // Burst payload is captured with the post-tick frame/phase
        if (mode_q == c_MODE_BLINK)
            w_burst_src = phase_d ? {pathi_d, patlo_d} : 24'h000000;
        else
            w_burst_src = frame_d;
    end

    // Burst FSM: IDLE -> WR_LO -> WR_HI, chaining straight into WR_LO when a tick waits
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        abort_d   = abort_q;
        burst_d   = burst_q;
        case (state_q)
            c_IDLE: begin
                abort_d = 1'b0;
                if (w_engine && (w_tick || pending_q)) begin
                    state_d   = c_WR_LO;
                    pending_d = 1'b0;
                    burst_d   = w_burst_src;
                end else if (!w_engine) begin
                    pending_d = 1'b0;
                end
            end
            c_WR_LO: begin
                state_d = c_WR_HI;
                if (w_tick_ok)     pending_d = 1'b1;
                if (w_ctrl_change) abort_d   = 1'b1;
            end
            c_WR_HI: begin
                if (abort_q || w_ctrl_change || !w_engine) begin
                    state_d   = c_IDLE;
                    pending_d = 1'b0;
                    abort_d   = 1'b0;
                end else if (pending_q || w_tick_ok) begin
                    state_d   = c_WR_LO;
                    pending_d = 1'b0;
                    burst_d   = w_burst_src;
                end else begin
                    state_d = c_IDLE;
                end
            end
            default: begin
                state_d   = c_IDLE;
                pending_d = 1'b0;
                abort_d   = 1'b0;
            end
        endcase
    end

    // DIRECT forwarder: one-cycle echo of a pattern write, held off while a burst owns the port
    always_comb begin
        fwd_d      = fwd_q && (state_q != c_IDLE);
        fwd_addr_d = fwd_addr_q;
        fwd_data_d = fwd_data_q;
        if (w_fwd_wr) begin
            fwd_d      = 1'b1;
            fwd_addr_d = bus.cpu_addr[1:0];
            fwd_data_d = w_wr_patlo ? bus.cpu_wdata : {8'h00, bus.cpu_wdata[7:0]};
        end
    end

    // All state registers, asynchronously cleared
    always_ff @(posedge ledctl_clk or negedge ledctl_rst) begin
        if (!ledctl_rst) begin
            patlo_q    <= 16'd0;
            pathi_q    <= 8'd0;
            mode_q     <= 2'd0;
            en_q       <= 1'b0;
            ovf_q      <= 1'b0;
            period_q   <= DEFAULT_PERIOD;
            frame_q    <= 24'd0;
            presc_q    <= 16'd0;
            phase_q    <= 1'b0;
            pending_q  <= 1'b0;
            abort_q    <= 1'b0;
            state_q    <= c_IDLE;
            burst_q    <= 24'd0;
            fwd_q      <= 1'b0;
            fwd_addr_q <= 2'd0;
            fwd_data_q <= 16'd0;
        end else begin
            patlo_q    <= patlo_d;
            pathi_q    <= pathi_d;
            mode_q     <= mode_d;
            en_q       <= en_d;
            ovf_q      <= ovf_d;
            period_q   <= period_d;
            frame_q    <= frame_d;
            presc_q    <= presc_d;
            phase_q    <= phase_d;
            pending_q  <= pending_d;
            abort_q    <= abort_d;
            state_q    <= state_d;
            burst_q    <= burst_d;
            fwd_q      <= fwd_d;
            fwd_addr_q <= fwd_addr_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // LED port mux: the FSM owns the port whenever it is not idle
    always_comb begin
        bus.led_cs    = 1'b0;
        bus.led_write = 1'b0;
        bus.led_addr  = 2'b00;
        bus.led_wdata = 16'd0;
        bus.busy      = (state_q != c_IDLE);
        if (state_q == c_WR_LO) begin
            bus.led_cs    = 1'b1;
            bus.led_write = 1'b1;
            bus.led_addr  = 2'b00;
            bus.led_wdata = burst_q[15:0];
        end else if (state_q == c_WR_HI) begin
            bus.led_cs    = 1'b1;
            bus.led_write = 1'b1;
            bus.led_addr  = 2'b10;
            bus.led_wdata = {8'h00, burst_q[23:16]};
        end else if (fwd_q) begin
            bus.led_cs    = 1'b1;
            bus.led_write = 1'b1;
            bus.led_addr  = fwd_addr_q;
            bus.led_wdata = fwd_data_q;
        end
    end

    // Register readback, combinational on the offset
    always_comb begin
        case (bus.cpu_addr)
            c_ADDR_PATLO:  bus.cpu_rdata = patlo_q;
            c_ADDR_PATHI:  bus.cpu_rdata = {8'h00, pathi_q};
            c_ADDR_CTRL:   bus.cpu_rdata = {12'd0, ovf_q, en_q, mode_q};
            c_ADDR_PERIOD: bus.cpu_rdata = period_q;
            default:       bus.cpu_rdata = 16'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_seq_ctrl
// Description : Self-checking bench for led_seq_ctrl. Register vectors come
//               from a table; LED beats are checked against a queue of
//               expected {cycle, addr, data} records.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_seq_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led_seq_ctrl_if bus ();

    led_seq_ctrl #(.DEFAULT_PERIOD(16'd1000)) dut (
        .ledctl_clk (clk),
        .ledctl_rst (rst_n),
        .bus        (bus)
    );

    typedef struct {
        int          cyc;
        logic [1:0]  addr;
        logic [15:0] data;
    } beat_t;

    typedef struct {
        logic        wr;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic [2:0]  raddr;
        logic [15:0] exp;
    } vec_t;

    beat_t exp_q[$];
    beat_t mon_e;
    vec_t  tbl[11];

    // Scoreboard: every strobe on the LED port must match the next expected beat
    always @(negedge clk) begin
        if (rst_n && bus.led_cs && bus.led_write) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: cyc=%0d addr=%b data=%h, required no beat",
                         cyc, bus.led_addr, bus.led_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.addr != bus.led_addr || mon_e.data != bus.led_wdata) begin
                    errors++;
                    $display("FAIL beat: got cyc=%0d addr=%b data=%h, required cyc=%0d addr=%b data=%h",
                             cyc, bus.led_addr, bus.led_wdata, mon_e.cyc, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [1:0] a, input logic [15:0] d);
        beat_t b;
        b.cyc = c; b.addr = a; b.data = d;
        exp_q.push_back(b);
    endtask

    task automatic push_frame(input int c, input logic [23:0] f);
        push(c, 2'b00, f[15:0]);
        push(c + 1, 2'b10, {8'h00, f[23:16]});
    endtask

    // Called at a negedge; the write lands on the next rising edge and returns at the following negedge
    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        bus.cpu_cs    = 1'b1;
        bus.cpu_write = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        @(negedge clk);
        bus.cpu_cs    = 1'b0;
        bus.cpu_write = 1'b0;
    endtask

    // Pattern write in DIRECT mode (or en=0): expect its echo in the cycle after the write edge
    task automatic wr_fwd(input logic [2:0] a, input logic [15:0] d);
        push(cyc + 1, a[1:0], (a == 3'd0) ? d : {8'h00, d[7:0]});
        wr(a, d);
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [15:0] exp);
        bus.cpu_addr = a;
        #1;
        chk(name, {16'd0, bus.cpu_rdata}, {16'd0, exp});
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int          w;
        logic [23:0] f;

        bus.cpu_cs    = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = 3'd0;
        bus.cpu_wdata = 16'd0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_led_cs", {31'd0, bus.led_cs}, 32'd0);
        chk("rst_busy",   {31'd0, bus.busy},   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- register table ----------------
        tbl[0]  = '{1'b0, 3'd0, 16'h0000, 3'd6, 16'h03E8};
        tbl[1]  = '{1'b0, 3'd0, 16'h0000, 3'd4, 16'h0000};
        tbl[2]  = '{1'b0, 3'd0, 16'h0000, 3'd0, 16'h0000};
        tbl[3]  = '{1'b0, 3'd0, 16'h0000, 3'd2, 16'h0000};
        tbl[4]  = '{1'b1, 3'd6, 16'h1234, 3'd6, 16'h1234};
        tbl[5]  = '{1'b1, 3'd7, 16'hFFFF, 3'd6, 16'h1234};
        tbl[6]  = '{1'b1, 3'd5, 16'h0007, 3'd4, 16'h0000};
        tbl[7]  = '{1'b1, 3'd4, 16'h000B, 3'd4, 16'h0003};
        tbl[8]  = '{1'b1, 3'd4, 16'h0000, 3'd4, 16'h0000};
        tbl[9]  = '{1'b1, 3'd3, 16'h00FF, 3'd2, 16'h0000};
        tbl[10] = '{1'b0, 3'd0, 16'h0000, 3'd1, 16'h0000};
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].wr) wr(tbl[i].waddr, tbl[i].wdata);
            rd($sformatf("tbl%0d", i), tbl[i].raddr, tbl[i].exp);
            @(negedge clk);
        end
        chk("tbl_no_beats", exp_q.size(), 0);

        // ---------------- DIRECT forwarding, back to back ----------------
        wr_fwd(3'd0, 16'hA5A5);
        wr_fwd(3'd2, 16'h003C);
        repeat (3) @(negedge clk);
        rd("direct_patlo", 3'd0, 16'hA5A5);
        rd("direct_pathi", 3'd2, 16'h003C);
        @(negedge clk);
        chk("direct_drained", exp_q.size(), 0);

        // ---------------- SHIFT, PERIOD=4, 24 ticks ----------------
        wr(3'd6, 16'd4);
        wr_fwd(3'd0, 16'h0001);
        wr_fwd(3'd2, 16'h0000);
        w = cyc + 1;
        f = 24'h000001;
        for (int n = 1; n <= 24; n++) begin
            f = {f[22:0], f[23]};
            push_frame(w + 4 * n, f);
        end
        wr(3'd4, 16'h0006);
        wait_until(w + 97);
        wr(3'd4, 16'h0000);
        repeat (6) @(negedge clk);
        chk("shift_drained", exp_q.size(), 0);
        chk("shift_idle", {31'd0, bus.busy}, 32'd0);

        // ---------------- COUNT wrap, PERIOD=0, pending path ----------------
        wr(3'd6, 16'd0);
        wr_fwd(3'd0, 16'hFFFE);
        wr_fwd(3'd2, 16'h00FF);
        w = cyc + 1;
        push_frame(w + 1, 24'hFFFFFF);
        push_frame(w + 3, 24'h000000);
        push_frame(w + 5, 24'h000001);
        wr(3'd4, 16'h0007);
        wait_until(w + 4);
        rd("count_ovf_set", 3'd4, 16'h000F);
        wait_until(w + 5);
        wr(3'd4, 16'h0000);
        chk("count_busy_whi", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        chk("count_idle", {31'd0, bus.busy}, 32'd0);
        rd("count_ovf_sticky", 3'd4, 16'h0008);
        @(negedge clk);
        wr(3'd4, 16'h0008);
        rd("count_ovf_clr", 3'd4, 16'h0000);
        repeat (4) @(negedge clk);
        chk("count_drained", exp_q.size(), 0);

        // ---------------- BLINK, PERIOD=10, en cleared mid-burst ----------------
        wr(3'd6, 16'd10);
        wr_fwd(3'd0, 16'h3456);
        wr_fwd(3'd2, 16'h0012);
        w = cyc + 1;
        push(w + 10, 2'b00, 16'h3456); push(w + 11, 2'b10, 16'h0012);
        push(w + 20, 2'b00, 16'h0000); push(w + 21, 2'b10, 16'h0000);
        push(w + 30, 2'b00, 16'h3456); push(w + 31, 2'b10, 16'h0012);
        wr(3'd4, 16'h0005);
        wait_until(w + 30);
        wr(3'd4, 16'h0001);
        chk("blink_busy_whi", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        chk("blink_idle", {31'd0, bus.busy}, 32'd0);
        wait_until(w + 45);
        chk("blink_drained", exp_q.size(), 0);

        // ---------------- PERIOD write during WR_LO ----------------
        wr_fwd(3'd0, 16'h0000);
        wr_fwd(3'd2, 16'h0000);
        wr(3'd6, 16'd5);
        w = cyc + 1;
        push_frame(w + 5,  24'h000001);
        push_frame(w + 10, 24'h000002);
        push_frame(w + 19, 24'h000003);
        push_frame(w + 27, 24'h000004);
        wr(3'd4, 16'h0007);
        wait_until(w + 10);
        wr(3'd6, 16'd8);
        wait_until(w + 27);
        wr(3'd4, 16'h0000);
        wait_until(w + 35);
        chk("coll_idle", {31'd0, bus.busy}, 32'd0);
        chk("coll_drained", exp_q.size(), 0);

        // ---------------- asynchronous reset mid-burst ----------------
        wr(3'd6, 16'd4);
        w = cyc + 1;
        push(w + 4, 2'b00, 16'h0001);
        wr(3'd4, 16'h0007);
        wait_until(w + 4);
        chk("rst_pre_busy", {31'd0, bus.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_cs",    {31'd0, bus.led_cs},    32'd0);
        chk("rst_async_write", {31'd0, bus.led_write}, 32'd0);
        chk("rst_async_data",  {16'd0, bus.led_wdata}, 32'd0);
        chk("rst_async_busy",  {31'd0, bus.busy},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd("rst_period", 3'd6, 16'h03E8);
        rd("rst_ctrl",   3'd4, 16'h0000);
        rd("rst_patlo",  3'd0, 16'h0000);
        repeat (8) @(negedge clk);
        chk("rst_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
